// File: rtl/cmd_exec.sv
// Command responder: executes one bus command per accepted strobe and reports a done pulse.
// Single-cycle ops finish in one cycle; MULT/DIV/REM iterate W cycles while busy is high.
module cmd_exec #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic [2:0]   cmd,
  input  logic [W-1:0] opd1,
  input  logic [W-1:0] opd2,
  output logic         done,
  output logic [2:0]   done_cmd,
  output logic [W-1:0] result,
  output logic         err,
  output logic         busy,
  output logic         ovr,
  output logic [1:0]   state_dbg
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] C_RST  = 3'd0;
  localparam logic [2:0] C_INIT = 3'd1;
  localparam logic [2:0] C_ADD  = 3'd2;
  localparam logic [2:0] C_SUB  = 3'd3;
  localparam logic [2:0] C_MULT = 3'd4;
  localparam logic [2:0] C_DIV  = 3'd5;
  localparam logic [2:0] C_HLT  = 3'd7;

  typedef enum logic [1:0] {S_UNINIT, S_READY, S_ITER, S_HALTED} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     op, op_n;
  logic [W-1:0]   a, a_n, b, b_n, acc, acc_n;
  logic           done_n, err_n, ovr_n;
  logic [2:0]     done_cmd_n;
  logic [W-1:0]   result_n;

  // Datapath for one iteration. MULT: acc += a when b[0], a<<=1, b>>=1.
  // DIV/REM: acc is the partial remainder, b shifts dividend bits out and quotient bits in.
  logic [W:0]     rs;
  logic           sub_ok;
  logic [W-1:0]   diff, mul_acc;

  assign rs      = {acc, b[W-1]};
  assign sub_ok  = rs >= {1'b0, a};
  assign diff    = rs[W-1:0] - a;
  assign mul_acc = b[0] ? acc + a : acc;

  assign busy      = (state == S_ITER);
  assign state_dbg = state;

  // Handshake: a command is taken at a rising edge with rdy=1 and busy=0; rdy=1 with
  // busy=1 drops the command and raises ovr for one cycle. Each taken command yields
  // exactly one done pulse carrying its code, result and err.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    op_n       = op;
    a_n        = a;
    b_n        = b;
    acc_n      = acc;
    done_n     = 1'b0;
    err_n      = 1'b0;
    ovr_n      = 1'b0;
    done_cmd_n = done_cmd;
    result_n   = result;

    if (state == S_ITER) begin
      ovr_n = rdy;
      cnt_n = cnt + CW'(1);
      if (op == C_MULT) begin
        acc_n = mul_acc;
        a_n   = a << 1;
        b_n   = b >> 1;
      end else begin
        acc_n = sub_ok ? diff : rs[W-1:0];
        b_n   = {b[W-2:0], sub_ok};
      end
      if (cnt == CW'(W - 1)) begin
        done_n     = 1'b1;
        done_cmd_n = op;
        state_n    = S_READY;
        result_n   = (op == C_MULT) ? acc_n : (op == C_DIV) ? b_n : acc_n;
      end
    end else if (rdy) begin
      done_n     = 1'b1;
      done_cmd_n = cmd;
      case (state)
        S_UNINIT: begin
          if (cmd == C_INIT) begin
            result_n = opd1;
            state_n  = S_READY;
          end else if (cmd == C_RST) begin
            result_n = '0;
          end else begin
            err_n = 1'b1;
          end
        end
        S_READY: begin
          case (cmd)
            C_RST: begin
              result_n = '0;
              state_n  = S_UNINIT;
            end
            C_INIT: result_n = opd1;
            C_ADD:  result_n = opd1 + opd2;
            C_SUB:  result_n = opd1 - opd2;
            C_HLT:  state_n  = S_HALTED;
            default: begin
              if (cmd != C_MULT && opd2 == '0) begin
                // Divide by zero completes immediately without iterating.
                err_n    = 1'b1;
                result_n = (cmd == C_DIV) ? '1 : opd1;
              end else begin
                done_n     = 1'b0;
                done_cmd_n = done_cmd;
                op_n       = cmd;
                cnt_n      = '0;
                acc_n      = '0;
                a_n        = (cmd == C_MULT) ? opd1 : opd2;
                b_n        = (cmd == C_MULT) ? opd2 : opd1;
                state_n    = S_ITER;
              end
            end
          endcase
        end
        default: begin
          if (cmd == C_RST) begin
            result_n = '0;
            state_n  = S_UNINIT;
          end else if (cmd == C_INIT) begin
            result_n = opd1;
            state_n  = S_READY;
          end else begin
            err_n = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_UNINIT;
      cnt      <= '0;
      op       <= '0;
      a        <= '0;
      b        <= '0;
      acc      <= '0;
      done     <= 1'b0;
      done_cmd <= '0;
      result   <= '0;
      err      <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      op       <= op_n;
      a        <= a_n;
      b        <= b_n;
      acc      <= acc_n;
      done     <= done_n;
      done_cmd <= done_cmd_n;
      result   <= result_n;
      err      <= err_n;
      ovr      <= ovr_n;
    end
  end

endmodule

// File: tb/tb_cmd_exec.sv
// Bench for cmd_exec: directed scenarios plus random traffic against a behavioural model
// that computes results with plain arithmetic and a countdown for iterative commands.
module tb_cmd_exec;

  localparam int W = 64;

  localparam logic [2:0] C_RST  = 3'd0;
  localparam logic [2:0] C_INIT = 3'd1;
  localparam logic [2:0] C_ADD  = 3'd2;
  localparam logic [2:0] C_SUB  = 3'd3;
  localparam logic [2:0] C_MULT = 3'd4;
  localparam logic [2:0] C_DIV  = 3'd5;
  localparam logic [2:0] C_REM  = 3'd6;
  localparam logic [2:0] C_HLT  = 3'd7;

  localparam int M_UNINIT = 0;
  localparam int M_READY  = 1;
  localparam int M_HALTED = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy;
  logic [2:0]   cmd;
  logic [W-1:0] opd1, opd2;
  logic         done, err, busy, ovr;
  logic [2:0]   done_cmd;
  logic [W-1:0] result;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad   = 0;

  // Model state
  int           m_state;
  int           m_cnt;
  logic [W-1:0] m_res, m_pend_res;
  logic [2:0]   m_dcmd, m_pend_cmd;
  logic         m_done, m_err, m_ovr;
  logic [W-1:0] exp_q[$];

  cmd_exec #(.W(W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .cmd(cmd), .opd1(opd1), .opd2(opd2),
    .done(done), .done_cmd(done_cmd), .result(result), .err(err),
    .busy(busy), .ovr(ovr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic complete(input logic [2:0] c, input logic [W-1:0] v, input logic e);
    m_done = 1'b1;
    m_dcmd = c;
    m_res  = v;
    m_err  = e;
    exp_q.push_back(v);
  endtask

  task automatic begin_iter(input logic [2:0] c, input logic [W-1:0] v);
    m_pend_cmd = c;
    m_pend_res = v;
    m_cnt      = W;
    exp_q.push_back(v);
  endtask

  task automatic model_step(input logic r, input logic rd, input logic [2:0] c,
                            input logic [W-1:0] x, input logic [W-1:0] y);
    if (!r) begin
      m_state = M_UNINIT; m_cnt = 0; m_res = '0; m_dcmd = '0;
      m_done = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
      exp_q.delete();
      return;
    end
    m_done = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
    if (m_cnt > 0) begin
      m_ovr = rd;
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1; m_dcmd = m_pend_cmd; m_res = m_pend_res; m_state = M_READY;
      end
    end else if (rd) begin
      if (m_state == M_READY) begin
        case (c)
          C_RST:  begin complete(c, '0, 1'b0); m_state = M_UNINIT; end
          C_INIT: complete(c, x, 1'b0);
          C_ADD:  complete(c, x + y, 1'b0);
          C_SUB:  complete(c, x - y, 1'b0);
          C_HLT:  begin complete(c, m_res, 1'b0); m_state = M_HALTED; end
          C_MULT: begin_iter(c, x * y);
          C_DIV:  if (y == '0) complete(c, '1, 1'b1); else begin_iter(c, x / y);
          default: if (y == '0) complete(c, x, 1'b1); else begin_iter(c, x % y);
        endcase
      end else if (c == C_INIT) begin
        complete(c, x, 1'b0);
        m_state = M_READY;
      end else if (c == C_RST) begin
        complete(c, '0, 1'b0);
        m_state = M_UNINIT;
      end else begin
        complete(c, m_res, 1'b1);
      end
    end
  endtask

  task automatic compare();
    check("done", 64'(done), 64'(m_done));
    check("err", 64'(err), 64'(m_err));
    check("busy", 64'(busy), 64'(m_cnt > 0));
    check("ovr", 64'(ovr), 64'(m_ovr));
    check("done_cmd", 64'(done_cmd), 64'(m_dcmd));
    check("result", result, m_res);
    if (done) begin
      check("sb_pending", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) check("sb_result", result, exp_q.pop_front());
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic [2:0] c,
                      input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    rst = r; rdy = rd; cmd = c; opd1 = x; opd2 = y;
    @(posedge clk);
    model_step(r, rd, c, x, y);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  function automatic logic [W-1:0] rand_opd();
    case ($urandom_range(0, 3))
      0: return {$urandom, $urandom};
      1: return W'($urandom_range(0, 1000));
      2: return W'($urandom);
      default: return {$urandom, 32'h0} | W'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    rst = 1'b0; rdy = 1'b0; cmd = '0; opd1 = '0; opd2 = '0;
    step(1'b0, 1'b0, C_RST, '0, '0);
    step(1'b0, 1'b1, C_INIT, 64'd9, 64'd9);
    check("reset_result", result, '0);

    // ADD while uninitialised
    step(1'b1, 1'b1, C_ADD, 64'd5, 64'd7);
    check("uninit_add_err", 64'(err), 64'(1));
    check("uninit_add_cmd", 64'(done_cmd), 64'(2));

    // Back-to-back single-cycle ops
    step(1'b1, 1'b1, C_INIT, 64'd10, 64'd0);
    check("init10", result, 64'd10);
    step(1'b1, 1'b1, C_ADD, 64'd3, 64'd4);
    check("add34", result, 64'd7);
    step(1'b1, 1'b1, C_SUB, 64'd0, 64'd1);
    check("sub01", result, 64'hFFFF_FFFF_FFFF_FFFF);

    // MULT with a dropped ADD during busy
    step(1'b1, 1'b1, C_MULT, 64'h1_0000_0001, 64'h1_0000_0001);
    step(1'b1, 1'b1, C_ADD, 64'd1, 64'd1);
    check("mult_ovr", 64'(ovr), 64'(1));
    idle(62);
    check("mult_busy_last", 64'(busy), 64'(1));
    idle(1);
    check("mult_done", 64'(done), 64'(1));
    check("mult_result", result, 64'h0000_0002_0000_0001);
    idle(1);

    // DIV, REM in DIV's done cycle, then divide by zero
    step(1'b1, 1'b1, C_DIV, 64'd100, 64'd7);
    idle(64);
    check("div_result", result, 64'd14);
    step(1'b1, 1'b1, C_REM, 64'd100, 64'd7);
    idle(64);
    check("rem_result", result, 64'd2);
    step(1'b1, 1'b1, C_DIV, 64'd9, 64'd0);
    check("div0_err", 64'(err), 64'(1));
    check("div0_result", result, 64'hFFFF_FFFF_FFFF_FFFF);

    // HALTED behaviour
    step(1'b1, 1'b1, C_HLT, 64'd0, 64'd0);
    check("hlt_cmd", 64'(done_cmd), 64'(7));
    step(1'b1, 1'b1, C_ADD, 64'd1, 64'd2);
    check("halted_add_err", 64'(err), 64'(1));
    step(1'b1, 1'b1, C_INIT, 64'd3, 64'd0);
    check("halted_init", result, 64'd3);

    // Reset in the middle of a division
    step(1'b1, 1'b1, C_DIV, 64'd50, 64'd3);
    idle(19);
    step(1'b0, 1'b1, C_ADD, 64'd1, 64'd1);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_result", result, '0);
    idle(70);
    step(1'b1, 1'b1, C_ADD, 64'd1, 64'd1);
    check("abort_uninit_err", 64'(err), 64'(1));

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] c;
      logic [W-1:0] y;
      c = 3'($urandom_range(0, 7));
      if (c == C_RST && $urandom_range(0, 3) != 0) c = C_INIT;
      y = ($urandom_range(0, 7) == 0) ? '0 : rand_opd();
      step($urandom_range(0, 299) != 0, $urandom_range(0, 2) != 0, c, rand_opd(), y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
